// File: rtl/asyn_fifo_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : asyn_fifo_pkg
// Description : Shared types and constants for the async FIFO burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
package asyn_fifo_pkg;

    // Burst reader control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Output skid buffer depth and the width of its occupancy counter
    localparam int OBUF_DEPTH    = 2;
    localparam int OBUF_CNT_BITS = $clog2(OBUF_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/asyn_fifo_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Interface   : asyn_fifo_burst_reader_if
// Description : FIFO read port plus downstream valid/ready stream bundle.
//               master = burst reader, slave = FIFO/downstream environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface asyn_fifo_burst_reader_if #(
    parameter int DATA_BITS = 10
);
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_read;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_last;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_read, out_valid, out_data, out_last
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_read, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/asyn_fifo_burst_reader_stream_buf2.sv
`default_nettype none
// ============================================================================
// Module      : stream_buf2
// Description : Two-entry shift-style buffer; head entry always in r_head so
//               the output is driven straight from a register.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_buf2
    import asyn_fifo_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         head_data,
    output logic      [OBUF_CNT_BITS-1:0] count
);
    localparam logic [OBUF_CNT_BITS-1:0] c_one  = OBUF_CNT_BITS'(1);
    localparam logic [OBUF_CNT_BITS-1:0] c_full = OBUF_CNT_BITS'(OBUF_DEPTH);

    logic [WIDTH-1:0]         r_head;
    logic [WIDTH-1:0]         r_tail;
    logic [OBUF_CNT_BITS-1:0] r_count;
    logic                     w_push;
    logic                     w_pop;

    // Protect against overflow/underflow even if the caller misbehaves
    assign w_push = push && (r_count != c_full);
    assign w_pop  = pop && (r_count != '0);

    // Occupancy and storage update; simultaneous push/pop keeps the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == '0) r_head <= push_data;
                    else               r_tail <= push_data;
                    r_count <= r_count + c_one;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - c_one;
                end
                2'b11: begin
                    if (r_count == c_one) begin
                        r_head <= push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = r_head;
    assign count     = r_count;
endmodule
`default_nettype wire

// File: rtl/asyn_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : asyn_fifo_burst_reader
// Description : Read-domain consumer for the async FIFO. Pops exactly
//               burst_len words and forwards them as a valid/ready stream
//               with a last marker through a 2-entry output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module asyn_fifo_burst_reader
    import asyn_fifo_pkg::*;
#(
    parameter int DATA_BITS = 10,
    parameter int LEN_BITS  = 8,
    parameter int CNT_BITS  = 16
) (
    input  wire logic                r_clk,
    input  wire logic                r_reset,
    input  wire logic                start,
    input  wire logic [LEN_BITS-1:0] burst_len,
    asyn_fifo_burst_reader_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic      [CNT_BITS-1:0] words_total
);
    localparam logic [LEN_BITS-1:0]      c_len_one   = LEN_BITS'(1);
    localparam logic [CNT_BITS-1:0]      c_cnt_one   = CNT_BITS'(1);
    localparam logic [OBUF_CNT_BITS-1:0] c_obuf_full = OBUF_CNT_BITS'(OBUF_DEPTH);

    rd_state_t                r_state;
    logic [LEN_BITS-1:0]      r_remaining;
    logic                     r_busy;
    logic                     r_done;
    logic [CNT_BITS-1:0]      r_words_total;

    logic                     w_pop_fifo;
    logic                     w_out_valid;
    logic                     w_accept;
    logic [DATA_BITS:0]       w_push_data;
    logic [DATA_BITS:0]       w_head;
    logic [OBUF_CNT_BITS-1:0] w_buf_cnt;

    // Pop decision uses only registered state and the FIFO's registered
    // empty flag, never out_ready, so no combinational path to downstream.
    assign w_pop_fifo  = (r_state == BURST) && !bus.fifo_empty &&
                         (w_buf_cnt < c_obuf_full) && (r_remaining != '0);
    assign w_push_data = {bus.fifo_data, (r_remaining == c_len_one)};
    assign w_out_valid = (w_buf_cnt != '0);
    assign w_accept    = w_out_valid && bus.out_ready;

    stream_buf2 #(
        .WIDTH (DATA_BITS + 1)
    ) u_obuf (
        .clk       (r_clk),
        .rst_n     (r_reset),
        .push      (w_pop_fifo),
        .push_data (w_push_data),
        .pop       (w_accept),
        .head_data (w_head),
        .count     (w_buf_cnt)
    );

    // Burst control: accept start, count pops, wait for the last word to leave
    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A start coinciding with the completion pulse is dropped
                    if (start && !r_done) begin
                        if (burst_len != '0) begin
                            r_remaining <= burst_len;
                            r_busy      <= 1'b1;
                            r_state     <= BURST;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (w_pop_fifo) begin
                        r_remaining <= r_remaining - c_len_one;
                        if (r_remaining == c_len_one) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_accept && w_head[0]) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Delivered-word counter, wraps naturally
    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            r_words_total <= '0;
        end else if (w_accept) begin
            r_words_total <= r_words_total + c_cnt_one;
        end
    end

    assign bus.fifo_read = w_pop_fifo;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_head[DATA_BITS:1];
    assign bus.out_last  = w_head[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign words_total   = r_words_total;
endmodule
`default_nettype wire
